serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while the bit-serial operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port diff, output, WIDTH bits: a minus b, modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: final borrow-out; 1 when a < b (unsigned).
REQ-011 SHALL have port zero, output, 1 bit: high when diff equals 0.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE; on acceptance it captures a and b into shift registers, clears the borrow flop and the bit counter, and enters SHIFT.
REQ-014 SHALL, in SHIFT, process one bit per cycle, LSB first: diff_bit = a0 ^ b0 ^ bin, bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
REQ-015 SHALL, in SHIFT, shift each diff_bit into the result register MSB-first-in, so that after WIDTH bits bit 0 is LSB.
REQ-016 SHALL, in SHIFT, register bout as the next bin.
REQ-017 SHALL, on the WIDTH-th SHIFT edge, update diff, borrow and zero and enter DONE.
REQ-018 SHALL give done latency exactly WIDTH clock edges after the edge that accepted start.
REQ-019 SHALL hold done high for exactly one cycle (the DONE state) and then return to IDLE.
REQ-020 SHALL hold busy high in SHIFT only; busy and done are never high together.
REQ-021 SHALL ignore start in SHIFT and DONE: no recapture, no restart, no error.
REQ-022 SHALL accept a start asserted in the cycle after DONE (back-to-back operations).
REQ-023 SHALL hold diff, borrow and zero stable from one completion until the next completion or reset; they do not change during SHIFT.
REQ-024 SHALL produce the wrap-around result 2^WIDTH + a - b with borrow=1 when a < b, e.g. 0 - 1 gives all ones.
REQ-025 SHALL saturate the bit counter at WIDTH-1 compare and never wrap past it.

Reset
REQ-026 SHALL, on rst_n low at any time, immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, and clear the counter and shift registers.
REQ-027 SHALL, on reset mid-SHIFT, discard the partial result without any done pulse.
REQ-028 SHALL allow the first start to be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE, SHIFT, DONE) and the default WIDTH constant in a shared package, serial_arith_pkg.
REQ-030 SHALL instantiate one sub-module, full_subtractor (ports A, B, Bin, Diff, Bout), purely combinational, as the per-bit cell.
REQ-031 SHALL keep all remaining logic (FSM, counter, shift registers, borrow flop) in serial_subtractor.

Verification
REQ-032 SHALL exhaustively check full_subtractor: 8 input combinations -> Diff/Bout match the truth table (e.g. A=0,B=1,Bin=1 -> Diff=0,Bout=1).
REQ-033 SHALL check, at WIDTH=8, a=0x05, b=0x03 -> done 8 edges after start, with diff=0x02, borrow=0, zero=0.
REQ-034 SHALL check a=0x03, b=0x05 -> diff=0xFE, borrow=1; and a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-035 SHALL check a=0xFF, b=0xFF -> diff=0x00, borrow=0, zero=1.
REQ-036 SHALL check a=0x10, b=0x01 started with start held high through SHIFT and operands changed to 0x00/0x00 mid-operation -> one done pulse with diff=0x0F, followed by a back-to-back result diff=0x00 only after the cycle following DONE.
REQ-037 SHALL check rst_n pulsed low during bit 4 of a=0x80, b=0x01 -> all outputs 0 and no done; then a=0x80, b=0x01 rerun -> diff=0x7F, borrow=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and a counter-sizing helper.
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bits needed to count 0..width-1; a 1-bit counter is the floor.
   function automatic int count_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: the per-bit cell of the serial subtractor.
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, one bit per
// clock LSB first, with final borrow and zero flags.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output state_t           dbg_state
);

   // Handshake: start is a request taken only in IDLE (operands sampled on
   // that edge); done is a one-cycle valid pulse with no ready, and
   // diff/borrow/zero hold their value until the next completion.

   localparam int              CW   = count_bits(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             bin_q;
   logic [CW-1:0]    cnt;
   logic             bit_diff;
   logic             bit_bout;

   full_subtractor u_cell (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Bin  (bin_q),
      .Diff (bit_diff),
      .Bout (bit_bout)
   );

   // Result enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
   assign res_next = {bit_diff, res_sr[WIDTH-1:1]};

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_bit   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST) begin
               last_bit   = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         bin_q  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         res_sr <= '0;
         bin_q  <= 1'b0;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_next;
         bin_q  <= bit_bout;
         // Counter stops at the last bit index instead of wrapping.
         if (!last_bit) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else if (last_bit) begin
         diff   <= res_next;
         borrow <= bit_bout;
         zero   <= (res_next == '0);
      end
   end

   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign dbg_state = state;

   busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
module tb_serial_subtractor;
   import serial_arith_pkg::*;

   localparam int W = 8;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  diff;
   logic          borrow;
   logic          zero;
   state_t        dbg_state;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero),
      .dbg_state (dbg_state)
   );

   logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;
   full_subtractor u_fs (
      .A    (fs_a),
      .B    (fs_b),
      .Bin  (fs_bin),
      .Diff (fs_diff),
      .Bout (fs_bout)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int done_count = 0;
   logic [W+1:0] exp_q[$];   // {zero, borrow, diff}
   logic [W+1:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W:0] d;
      d = {1'b0, av} - {1'b0, bv};
      return {(d[W-1:0] == '0), d[W], d[W-1:0]};
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         done_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got diff=0x%0h with no result outstanding", diff);
         end else begin
            mon_e = exp_q.pop_front();
            check("diff", {24'd0, diff}, {24'd0, mon_e[W-1:0]});
            check("borrow", {31'd0, borrow}, {31'd0, mon_e[W]});
            check("zero", {31'd0, zero}, {31'd0, mon_e[W+1]});
            check("busy_with_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge with the DUT in IDLE; returns just after the accept edge.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep_start);
      a = av;
      b = bv;
      start = 1'b1;
      exp_q.push_back(model(av, bv));
      @(posedge clk);
      #1;
      if (!keep_start) start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Waits for done after the accept edge; checks latency, output hold and pulse width.
   task automatic finish_op(input string tag);
      int edges;
      logic [W-1:0] held;
      bit stable;
      edges = 0;
      stable = 1'b1;
      held = diff;
      while (edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) break;
         if (diff !== held) stable = 1'b0;
      end
      check({tag, "_done_latency"}, edges, W);
      check({tag, "_hold_in_shift"}, {31'd0, stable}, 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
      int guard;
      guard = 0;
      @(negedge clk);
      while (dbg_state != IDLE && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      launch(av, bv, 1'b0);
      finish_op(tag);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic [W-1:0] exp_diff;
      logic         exp_borrow;
      logic         exp_zero;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int dc;
      int edges;
      int r;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

      rst_n = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      fs_a = 1'b0;
      fs_b = 1'b0;
      fs_bin = 1'b0;

      // Full subtractor cell, all 8 combinations against integer arithmetic.
      for (int i = 0; i < 8; i++) begin
         {fs_a, fs_b, fs_bin} = 3'(i);
         #1;
         r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
         check($sformatf("fs_diff_%0d", i), {31'd0, fs_diff}, 32'(r & 1));
         check($sformatf("fs_bout_%0d", i), {31'd0, fs_bout}, (r < 0) ? 32'd1 : 32'd0);
      end

      // Reset values.
      #2 rst_n = 1'b0;
      #1;
      check("rst_diff", {24'd0, diff}, 32'd0);
      check("rst_flags", {29'd0, borrow, zero, busy, done}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: model and table constants must agree, then the DUT is run.
      for (int i = 0; i < 6; i++) begin
         check($sformatf("table_%0d", i), {22'd0, model(vecs[i].av, vecs[i].bv)},
               {22'd0, vecs[i].exp_zero, vecs[i].exp_borrow, vecs[i].exp_diff});
         run_op(vecs[i].av, vecs[i].bv, $sformatf("vec%0d", i));
      end

      // Random operands.
      for (int i = 0; i < 8; i++) begin
         run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
      end

      // Start held high, operands changed mid-operation, then back-to-back run.
      @(negedge clk);
      launch(8'h10, 8'h01, 1'b1);
      exp_q.push_back(model(8'h00, 8'h00));
      repeat (3) @(posedge clk);
      #1;
      a = 8'h00;
      b = 8'h00;
      edges = 3;
      while (edges < 40 && !done) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("held_start_latency", edges, W);
      @(posedge clk);
      #1;
      check("after_done_idle", {30'd0, busy, done}, 32'd0);
      @(posedge clk);
      #1;
      check("back_to_back_accept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      finish_op("b2b");

      // Reset mid-SHIFT during bit 4, then rerun straight out of reset.
      @(negedge clk);
      dc = done_count;
      a = 8'h80;
      b = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_diff", {24'd0, diff}, 32'd0);
      check("midrst_flags", {29'd0, borrow, zero, busy, done}, 32'd0);
      check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_done", done_count, dc);
      check("midrst_still_clear", {21'd0, diff, borrow, zero, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'h80, 8'h01, 1'b0);
      finish_op("rerun");
      @(negedge clk);
      check("rerun_diff_held", {24'd0, diff}, 32'h7F);
      check("rerun_borrow_held", {31'd0, borrow}, 32'd0);

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
